// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and key-event signals between scanner and its neighbours
interface keypad_scanner_if;
  logic [3:0] Row;
  logic [2:0] Col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  Row,
    output Col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output Row,
    input  Col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 keypad column scanner with whole-frame press/release debounce
module keypad_scanner #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic              clock,
  input  logic              reset,
  keypad_scanner_if.master  kp
);

  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int CNTW = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  logic [DIVW-1:0] div_q;
  logic [1:0]      col_idx_q;
  logic [2:0]      col_q;
  logic [11:0]     hit_q;
  state_t          state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;

  logic            slot_end, frame_end;
  logic [11:0]     sample_vec, frame_vec;
  logic [3:0]      nbits, idx;
  logic            is_none, is_single;

  assign slot_end  = (div_q == DIVW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (col_idx_q == 2'd2);

  // The column-2 sample is merged combinationally so the frame is classified on its final cycle.
  always_comb begin
    sample_vec = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (col_idx_q == 2'(c)) sample_vec[r*3+c] = kp.Row[r];
      end
    end
    frame_vec = hit_q | sample_vec;
  end

  always_comb begin
    nbits = '0;
    idx   = '0;
    for (int i = 0; i < 12; i++) nbits = nbits + 4'(frame_vec[i]);
    for (int i = 11; i >= 0; i--) begin
      if (frame_vec[i]) idx = 4'(i);
    end
    is_none   = (nbits == 4'd0);
    is_single = (nbits == 4'd1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q     <= '0;
      col_idx_q <= '0;
      col_q     <= 3'b001;
      hit_q     <= '0;
    end else if (slot_end) begin
      div_q     <= '0;
      col_idx_q <= (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
      col_q     <= {col_q[1:0], col_q[2]};
      hit_q     <= frame_end ? 12'd0 : frame_vec;
    end else begin
      div_q     <= div_q + DIVW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    if (frame_end) begin
      unique case (state_q)
        IDLE: begin
          if (is_single) begin
            state_d = DEBOUNCE;
            cand_d  = idx;
            cnt_d   = CNTW'(1);
          end
        end
        DEBOUNCE: begin
          if (is_single && idx == cand_q) begin
            if (cnt_q + CNTW'(1) == CNTW'(DEBOUNCE_FRAMES)) begin
              state_d = PRESSED;
              code_d  = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end else if (is_single) begin
            cand_d = idx;
            cnt_d  = CNTW'(1);
          end else begin
            state_d = IDLE;
          end
        end
        PRESSED: begin
          if (!(is_single && idx == code_q)) begin
            state_d = RELEASE;
            cnt_d   = is_none ? CNTW'(1) : CNTW'(0);
          end
        end
        RELEASE: begin
          if (is_none) begin
            if (cnt_q + CNTW'(1) == CNTW'(DEBOUNCE_FRAMES)) begin
              state_d = IDLE;
              held_d  = 1'b0;
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end else if (is_single && idx == code_q) begin
            state_d = PRESSED;
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign kp.Col       = col_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized frame-level check of keypad_scanner against a run-length model
module tb_keypad_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DF       = 3;
  localparam int FRAME    = 3 * SCAN_DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] keys  = '0;

  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DF)) dut (
    .clock (clock),
    .reset (reset),
    .kp    (kif)
  );

  always #5 clock = ~clock;

  // Virtual keypad: a pressed key connects its column drive to its row line.
  always_comb begin
    kif.Row = '0;
    for (int r = 0; r < 4; r++) kif.Row[r] = |(kif.Col & keys[r*3 +: 3]);
  end

  int tests_run    = 0;
  int tests_failed = 0;

  // Acceptance = a run of DF identical single-key frames while nothing is held;
  // release = a run of DF empty frames while held.
  int   same_run, last_k, none_run, m_code, model_pulses, valid_seen;
  bit   m_held, m_valid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    same_run = 0; last_k = -1; none_run = 0;
    m_code = 0; m_held = 0; m_valid = 0;
  endtask

  task automatic model_update(input logic [11:0] mask);
    int n, k;
    n = $countones(mask);
    k = -1;
    for (int i = 11; i >= 0; i--) if (mask[i]) k = i;
    m_valid = 0;
    if (n == 1) begin
      if (same_run > 0 && k == last_k) same_run++;
      else begin same_run = 1; last_k = k; end
    end else same_run = 0;
    if (n == 0) none_run++; else none_run = 0;
    if (!m_held && n == 1 && same_run == DF) begin
      m_valid = 1; m_held = 1; m_code = k; model_pulses++;
    end else if (m_held && none_run == DF) begin
      m_held = 0;
    end
  endtask

  task automatic do_frame(input logic [11:0] mask, input int ncyc);
    int col_bad, extra;
    col_bad = 0; extra = 0;
    keys = mask;
    for (int i = 0; i < ncyc; i++) begin
      if (i == 0) begin
        check_eq("key_valid", 32'(kif.key_valid), 32'(m_valid));
        check_eq("key_held", 32'(kif.key_held), 32'(m_held));
        check_eq("key_code", 32'(kif.key_code), 32'(m_code));
      end else if (kif.key_valid) extra++;
      if (kif.key_valid) valid_seen++;
      if (kif.Col !== 3'(1 << (i / SCAN_DIV))) col_bad++;
      @(posedge clock); #1;
    end
    check_eq("col_seq", 32'(col_bad), 32'd0);
    check_eq("stray_valid", 32'(extra), 32'd0);
    if (ncyc == FRAME) model_update(mask);
  endtask

  task automatic check_reset_state();
    check_eq("rst_col", 32'(kif.Col), 32'd1);
    check_eq("rst_valid", 32'(kif.key_valid), 32'd0);
    check_eq("rst_held", 32'(kif.key_held), 32'd0);
    check_eq("rst_code", 32'(kif.key_code), 32'd0);
  endtask

  task automatic do_reset();
    keys  = '0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_reset_state();
    model_reset();
  endtask

  task automatic frames(input logic [11:0] mask, input int n);
    for (int i = 0; i < n; i++) do_frame(mask, FRAME);
  endtask

  initial begin
    int t, reps, ka, kb;
    logic [11:0] mask;
    model_pulses = 0; valid_seen = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_reset_state();

    // Key 7 from cycle 0: strobe at cycle 36, release after three empty frames.
    frames(12'(1 << 7), 3);
    check_eq("k7_valid_c36", 32'(kif.key_valid), 32'd1);
    check_eq("k7_code_c36", 32'(kif.key_code), 32'd7);
    frames(12'(1 << 7), 1);
    frames('0, 4);
    check_eq("k7_pulses", 32'(valid_seen), 32'd1);

    // Bounce on key 4.
    frames(12'(1 << 4), 2);
    frames('0, 1);
    frames(12'(1 << 4), 4);
    frames('0, 4);
    check_eq("k4_code", 32'(kif.key_code), 32'd4);

    // Keys 0 and 11 together, then key 11 released.
    frames(12'(1 << 0) | 12'(1 << 11), 10);
    frames(12'(1 << 0), 4);
    frames('0, 4);

    // Rollover: key 2 held, key 5 added then released.
    frames(12'(1 << 2), 4);
    frames(12'(1 << 2) | 12'(1 << 5), 5);
    frames(12'(1 << 2), 2);
    check_eq("roll_code", 32'(kif.key_code), 32'd2);
    frames('0, 4);

    // Reset mid-debounce on key 9.
    frames(12'(1 << 9), 2);
    do_reset();
    frames(12'(1 << 9), 4);
    frames('0, 4);
    check_eq("pulses_directed", 32'(valid_seen), 32'(model_pulses));

    for (int run = 0; run < 45; run++) begin
      t    = $urandom_range(0, 4);
      reps = $urandom_range(1, 5);
      ka   = $urandom_range(0, 11);
      kb   = (ka + $urandom_range(1, 11)) % 12;
      case (t)
        0:       mask = '0;
        1, 2:    mask = 12'(1 << ka);
        3:       mask = 12'(1 << ka) | 12'(1 << kb);
        default: mask = (last_k >= 0) ? 12'(1 << last_k) : '0;
      endcase
      frames(mask, reps);
      if (run % 15 == 14) begin
        do_frame(mask, $urandom_range(1, FRAME - 1));
        do_reset();
      end
    end
    frames('0, 4);
    check_eq("pulses_total", 32'(valid_seen), 32'(model_pulses));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
